fp_button_event_reporter: RTL and testbench

- Reverse direction of the FrontPanel wire-in to LED path: carries board push-button state from the FPGA to the host.
- Synchronises and debounces N raw button inputs, latches press events into sticky bits and counts presses.
- Presents all of this as one 32-bit word to drive an okWireOut endpoint. The host clears events by writing an acknowledge mask through an okWireIn endpoint.
- Sits beside the okHost/okWireOR fabric in the okClk domain.

---
 rtl/fp_status_pkg.sv | 25 ++
 rtl/fp_button_event_reporter_if.sv | 10 +
 rtl/fp_debounce.sv | 54 +++++
 rtl/fp_button_event_reporter.sv | 94 +++++++++
 tb/tb_fp_button_event_reporter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_status_pkg.sv
// Shared layout of the button status word and ack word, plus a popcount helper
// used to accumulate simultaneous presses.
package fp_status_pkg;

  localparam int MAX_CHANNELS = 8;

  localparam int CNT_LSB    = 16;
  localparam int CNT_WIDTH  = 16;
  localparam int STICKY_LSB = 8;
  localparam int STICKY_W   = 8;
  localparam int LEVEL_LSB  = 0;
  localparam int LEVEL_W    = 8;

  localparam int ACK_CNT_BIT = 31;

  function automatic logic [3:0] popcount8(input logic [MAX_CHANNELS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_CHANNELS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/fp_button_event_reporter_if.sv
// Host-facing wire bundle: ack mask from okWireIn, status word and pending flag
// toward okWireOut.
interface fp_button_event_reporter_if;
  logic [31:0] ack_wire;
  logic [31:0] status_word;
  logic        event_pending;

  modport master (output ack_wire, input status_word, input event_pending);
  modport slave  (input ack_wire, output status_word, output event_pending);
endinterface

// File: rtl/fp_debounce.sv
// One button channel: polarity fix, 2-flop synchroniser and a hold-time
// qualifier. rise_o is asserted in the cycle level_o is about to go 0->1.
module fp_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic okClk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          pressed;
  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign pressed = btn_raw_i ^ ACTIVE_LOW;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == TC) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pressed;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/fp_button_event_reporter.sv
// Debounced push-button state, sticky press events and a saturating press
// counter, packed into one registered 32-bit word for an okWireOut endpoint.
module fp_button_event_reporter
  import fp_status_pkg::*;
#(
  parameter int N_IN            = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = 16
) (
  input  logic                       okClk,
  input  logic                       rst_n,
  input  logic [N_IN-1:0]            btn_raw,
  fp_button_event_reporter_if.slave  bus
);

  logic [MAX_CHANNELS-1:0] level_w;
  logic [MAX_CHANNELS-1:0] rise_w;

  for (genvar g = 0; g < MAX_CHANNELS; g++) begin : g_ch
    if (g < N_IN) begin : g_on
      fp_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_deb (
        .okClk     (okClk),
        .rst_n     (rst_n),
        .btn_raw_i (btn_raw[g]),
        .level_o   (level_w[g]),
        .rise_o    (rise_w[g])
      );
    end else begin : g_off
      assign level_w[g] = 1'b0;
      assign rise_w[g]  = 1'b0;
    end
  end

  logic [N_IN-1:0]  sticky_q, sticky_d;
  logic [N_IN-1:0]  ack_prev_q;
  logic             ack_cnt_prev_q;
  logic             armed_q;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [31:0]      status_q, status_d;
  logic             event_pending_q;

  logic [N_IN-1:0]  ack_clr;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W:0]   cnt_sum;
  logic             unused_ack;

  // armed_q masks the first cycle after reset so an ack already high is not an edge
  assign ack_clr    = bus.ack_wire[N_IN-1:0] & ~ack_prev_q & {N_IN{armed_q}};
  assign cnt_clr    = bus.ack_wire[ACK_CNT_BIT] & ~ack_cnt_prev_q & armed_q;
  assign unused_ack = ^{bus.ack_wire[ACK_CNT_BIT-1:N_IN]};

  always_comb begin
    sticky_d    = (sticky_q & ~ack_clr) | rise_w[N_IN-1:0];
    cnt_base    = cnt_clr ? '0 : press_cnt_q;
    cnt_sum     = {1'b0, cnt_base} + {{(CNT_W-3){1'b0}}, popcount8(rise_w)};
    press_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_comb begin
    status_d = '0;
    status_d[CNT_LSB +: CNT_W]      = press_cnt_q;
    status_d[STICKY_LSB +: N_IN]    = sticky_q;
    status_d[LEVEL_LSB +: LEVEL_W]  = level_w;
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q        <= '0;
      ack_prev_q      <= '0;
      ack_cnt_prev_q  <= 1'b0;
      armed_q         <= 1'b0;
      press_cnt_q     <= '0;
      status_q        <= '0;
      event_pending_q <= 1'b0;
    end else begin
      sticky_q        <= sticky_d;
      ack_prev_q      <= bus.ack_wire[N_IN-1:0];
      ack_cnt_prev_q  <= bus.ack_wire[ACK_CNT_BIT];
      armed_q         <= 1'b1;
      press_cnt_q     <= press_cnt_d;
      status_q        <= status_d;
      event_pending_q <= |sticky_q;
    end
  end

  assign bus.status_word   = status_q;
  assign bus.event_pending = event_pending_q;

endmodule

// File: tb/tb_fp_button_event_reporter.sv
// Directed bench for fp_button_event_reporter with DEBOUNCE_CYCLES=8,
// ACTIVE_LOW=1, N_IN=4; press-to-status latency is 2+8+1 = 11 cycles.
module tb_fp_button_event_reporter;

  logic       okClk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 okClk = ~okClk;

  fp_button_event_reporter_if bus();

  fp_button_event_reporter #(
    .N_IN            (4),
    .DEBOUNCE_CYCLES (8),
    .ACTIVE_LOW      (1'b1),
    .CNT_W           (16)
  ) dut (
    .okClk   (okClk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .bus     (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge okClk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n        = 1'b0;
    btn_raw      = 4'hF;
    bus.ack_wire = 32'h0;
    #12;
    n_cmp++;
    if (bus.status_word !== 32'h0) begin
      n_err++;
      $display("FAIL reset_status: got %h want %h", bus.status_word, 32'h0);
    end
    n_cmp++;
    if (bus.event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pending: got %b want 0", bus.event_pending);
    end
    tick(2);
    rst_n = 1'b1;
    tick(3);
    n_cmp++;
    if (bus.status_word !== 32'h0) begin
      n_err++;
      $display("FAIL post_reset_status: got %h want %h", bus.status_word, 32'h0);
    end
  endtask

  task automatic test_glitch;
    int widths [2] = '{5, 7};
    foreach (widths[k]) begin
      btn_raw[0] = 1'b0;
      tick(widths[k]);
      btn_raw[0] = 1'b1;
      for (int c = 0; c < 16; c++) begin
        tick(1);
        n_cmp++;
        if (bus.status_word !== 32'h0 || bus.event_pending !== 1'b0) begin
          n_err++;
          $display("FAIL glitch_%0d_c%0d: got %h/%b want %h/0",
                   widths[k], c, bus.status_word, bus.event_pending, 32'h0);
        end
      end
    end
  endtask

  task automatic test_single_press;
    btn_raw[1] = 1'b0;
    tick(10);
    n_cmp++;
    if (bus.status_word !== 32'h0) begin
      n_err++;
      $display("FAIL press_early: got %h want %h", bus.status_word, 32'h0);
    end
    tick(1);
    n_cmp++;
    if (bus.status_word !== 32'h0001_0202) begin
      n_err++;
      $display("FAIL press_11: got %h want %h", bus.status_word, 32'h0001_0202);
    end
    n_cmp++;
    if (bus.event_pending !== 1'b1) begin
      n_err++;
      $display("FAIL press_pending: got %b want 1", bus.event_pending);
    end
    tick(9);
    btn_raw[1] = 1'b1;
    tick(10);
    n_cmp++;
    if (bus.status_word !== 32'h0001_0202) begin
      n_err++;
      $display("FAIL release_early: got %h want %h", bus.status_word, 32'h0001_0202);
    end
    tick(1);
    n_cmp++;
    if (bus.status_word !== 32'h0001_0200) begin
      n_err++;
      $display("FAIL release_11: got %h want %h", bus.status_word, 32'h0001_0200);
    end
    n_cmp++;
    if (bus.event_pending !== 1'b1) begin
      n_err++;
      $display("FAIL release_pending: got %b want 1", bus.event_pending);
    end
  endtask

  task automatic test_clear_edge;
    bus.ack_wire = 32'h2;
    tick(1);
    n_cmp++;
    if (bus.status_word !== 32'h0001_0200) begin
      n_err++;
      $display("FAIL clear_t1: got %h want %h", bus.status_word, 32'h0001_0200);
    end
    tick(1);
    n_cmp++;
    if (bus.status_word !== 32'h0001_0000 || bus.event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL clear_t2: got %h/%b want %h/0",
               bus.status_word, bus.event_pending, 32'h0001_0000);
    end
    btn_raw[1] = 1'b0;
    tick(11);
    n_cmp++;
    if (bus.status_word !== 32'h0002_0202 || bus.event_pending !== 1'b1) begin
      n_err++;
      $display("FAIL held_ack_press: got %h/%b want %h/1",
               bus.status_word, bus.event_pending, 32'h0002_0202);
    end
    tick(5);
    n_cmp++;
    if (bus.status_word !== 32'h0002_0202) begin
      n_err++;
      $display("FAIL held_ack_no_reclear: got %h want %h", bus.status_word, 32'h0002_0202);
    end
    btn_raw[1] = 1'b1;
    tick(11);
    n_cmp++;
    if (bus.status_word !== 32'h0002_0200) begin
      n_err++;
      $display("FAIL held_ack_release: got %h want %h", bus.status_word, 32'h0002_0200);
    end
    bus.ack_wire = 32'h0;
    tick(1);
    bus.ack_wire = 32'h2;
    tick(2);
    n_cmp++;
    if (bus.status_word !== 32'h0002_0000 || bus.event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL reclear: got %h/%b want %h/0",
               bus.status_word, bus.event_pending, 32'h0002_0000);
    end
    bus.ack_wire = 32'h0;
    tick(2);
  endtask

  task automatic test_set_clear_same;
    btn_raw[2] = 1'b0;
    tick(9);
    bus.ack_wire = 32'h4;
    tick(2);
    n_cmp++;
    if (bus.status_word !== 32'h0003_0404 || bus.event_pending !== 1'b1) begin
      n_err++;
      $display("FAIL set_wins: got %h/%b want %h/1",
               bus.status_word, bus.event_pending, 32'h0003_0404);
    end
    bus.ack_wire = 32'h0;
    btn_raw[2]   = 1'b1;
    tick(11);
    n_cmp++;
    if (bus.status_word !== 32'h0003_0400) begin
      n_err++;
      $display("FAIL set_wins_release: got %h want %h", bus.status_word, 32'h0003_0400);
    end
    btn_raw = 4'b0110;
    tick(9);
    bus.ack_wire = 32'h8000_0000;
    tick(2);
    n_cmp++;
    if (bus.status_word !== 32'h0002_0D09) begin
      n_err++;
      $display("FAIL cnt_clear_with_press: got %h want %h", bus.status_word, 32'h0002_0D09);
    end
    bus.ack_wire = 32'h0;
    btn_raw      = 4'hF;
    tick(11);
    n_cmp++;
    if (bus.status_word !== 32'h0002_0D00) begin
      n_err++;
      $display("FAIL multi_release: got %h want %h", bus.status_word, 32'h0002_0D00);
    end
  endtask

  task automatic test_saturation;
    force dut.press_cnt_q = 16'hFFFE;
    tick(1);
    release dut.press_cnt_q;
    tick(1);
    n_cmp++;
    if (bus.status_word !== 32'hFFFE_0D00) begin
      n_err++;
      $display("FAIL sat_preload: got %h want %h", bus.status_word, 32'hFFFE_0D00);
    end
    btn_raw = 4'b1100;
    tick(11);
    n_cmp++;
    if (bus.status_word !== 32'hFFFF_0F03) begin
      n_err++;
      $display("FAIL sat_two: got %h want %h", bus.status_word, 32'hFFFF_0F03);
    end
    btn_raw = 4'hF;
    tick(11);
    btn_raw = 4'b1011;
    tick(11);
    n_cmp++;
    if (bus.status_word !== 32'hFFFF_0F04) begin
      n_err++;
      $display("FAIL sat_hold: got %h want %h", bus.status_word, 32'hFFFF_0F04);
    end
    btn_raw = 4'hF;
    tick(11);
    n_cmp++;
    if (bus.status_word !== 32'hFFFF_0F00) begin
      n_err++;
      $display("FAIL sat_release: got %h want %h", bus.status_word, 32'hFFFF_0F00);
    end
  endtask

  task automatic test_counter_clear;
    bus.ack_wire = 32'h8000_0000;
    tick(2);
    n_cmp++;
    if (bus.status_word !== 32'h0000_0F00 || bus.event_pending !== 1'b1) begin
      n_err++;
      $display("FAIL cnt_clear: got %h/%b want %h/1",
               bus.status_word, bus.event_pending, 32'h0000_0F00);
    end
    bus.ack_wire = 32'h0;
    tick(1);
  endtask

  task automatic test_reset_mid;
    btn_raw[3] = 1'b0;
    tick(6);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.status_word !== 32'h0 || bus.event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_assert: got %h/%b want %h/0",
               bus.status_word, bus.event_pending, 32'h0);
    end
    tick(2);
    n_cmp++;
    if (bus.status_word !== 32'h0 || bus.event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_hold: got %h/%b want %h/0",
               bus.status_word, bus.event_pending, 32'h0);
    end
    rst_n = 1'b1;
    tick(10);
    n_cmp++;
    if (bus.status_word !== 32'h0 || bus.event_pending !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_requal_early: got %h/%b want %h/0",
               bus.status_word, bus.event_pending, 32'h0);
    end
    tick(1);
    n_cmp++;
    if (bus.status_word !== 32'h0001_0808 || bus.event_pending !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_requal: got %h/%b want %h/1",
               bus.status_word, bus.event_pending, 32'h0001_0808);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_press();
    test_clear_edge();
    test_set_clear_same();
    test_saturation();
    test_counter_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
